// File: rtl/vfr_ctrl_pkg.sv
// ============================================================================
// Module   : vfr_ctrl_pkg
// Brief    : Shared types and constants for the VIP control packet decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vfr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VIDEO   = 2'd1,
        CTRL    = 2'd2,
        DISCARD = 2'd3
    } vfr_state_t;

    localparam logic [3:0]  PKT_VIDEO    = 4'h0;
    localparam logic [3:0]  PKT_CTRL     = 4'hF;
    localparam int unsigned CTRL_SYMBOLS = 9;

endpackage

`default_nettype wire

// File: rtl/vfr_ctrl_symbol_capture.sv
// ============================================================================
// Module   : vfr_ctrl_symbol_capture
// Brief    : Symbol counter and 9-nibble shadow register for control payloads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vfr_ctrl_symbol_capture
    import vfr_ctrl_pkg::*;
#(
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic                                 capture,
    input  logic [SYMBOLS_PER_BEAT-1:0][3:0]     nibbles,
    output logic [CTRL_SYMBOLS-1:0][3:0]         shadow_next,
    output logic                                 complete
);

    logic [3:0]                      r_count;
    logic [CTRL_SYMBOLS-1:0][3:0]    r_shadow;
    logic [4:0]                      w_sum;
    logic [3:0]                      w_count_next;
    logic [4:0]                      w_idx;

    always_comb begin
        w_sum        = {1'b0, r_count} + 5'(SYMBOLS_PER_BEAT);
        w_count_next = (w_sum > 5'(CTRL_SYMBOLS)) ? 4'(CTRL_SYMBOLS) : w_sum[3:0];
        complete     = (w_count_next == 4'(CTRL_SYMBOLS));
    end

    // Shadow contents as they will be once the current beat is captured, so the
    // eop beat's own symbols can be published in the same clock.
    always_comb begin
        shadow_next = r_shadow;
        w_idx       = '0;
        for (int i = 0; i < SYMBOLS_PER_BEAT; i++) begin
            w_idx = {1'b0, r_count} + 5'(i);
            if (w_idx < 5'(CTRL_SYMBOLS)) begin
                shadow_next[w_idx[3:0]] = nibbles[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_shadow <= '0;
        end else if (clear) begin
            r_count  <= '0;
        end else if (capture) begin
            r_count  <= w_count_next;
            r_shadow <= shadow_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vfr_control_packet_decoder.sv
// ============================================================================
// Module   : vfr_control_packet_decoder
// Brief    : Avalon-ST VIP sink decoder: extracts frame geometry from control
//            packets, forwards video packets (RL0), drops everything else.
//            Optional: VFR_CTRL_DEC_PASSTHRU_EN also forwards control packets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vfr_control_packet_decoder
    import vfr_ctrl_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    output logic                                      din_ready,
    input  logic                                      din_valid,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                      din_sop,
    input  logic                                      din_eop,
    input  logic                                      dout_ready,
    output logic                                      dout_valid,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    output logic                                      dout_sop,
    output logic                                      dout_eop,
    output logic [15:0]                               width,
    output logic [15:0]                               height,
    output logic [3:0]                                interlaced,
    output logic                                      ctrl_valid,
    output logic                                      ctrl_error
);

    vfr_state_t                        r_state;
    vfr_state_t                        w_state_next;
    logic                              w_ready;
    logic                              w_fwd;
    logic                              w_ctrl_start;
    logic                              w_capture;
    logic                              w_valid_next;
    logic                              w_error_next;
    logic                              w_hdr_video;
    logic                              w_hdr_ctrl;
    logic                              w_pass_ctrl_hdr;
    logic                              w_complete;
    logic [SYMBOLS_PER_BEAT-1:0][3:0]  w_nibbles;
    logic [CTRL_SYMBOLS-1:0][3:0]      w_shadow_next;
    logic [15:0]                       r_width;
    logic [15:0]                       r_height;
    logic [3:0]                        r_interlaced;
    logic                              r_ctrl_valid;
    logic                              r_ctrl_error;

    genvar g;
    generate
        for (g = 0; g < SYMBOLS_PER_BEAT; g++) begin : g_sym
            assign w_nibbles[g] = din_data[g*BITS_PER_SYMBOL +: 4];
        end
    endgenerate

    assign w_hdr_video = din_sop && (din_data[3:0] == PKT_VIDEO);
    assign w_hdr_ctrl  = din_sop && (din_data[3:0] == PKT_CTRL);
`ifdef VFR_CTRL_DEC_PASSTHRU_EN
    assign w_pass_ctrl_hdr = w_hdr_ctrl;
`else
    assign w_pass_ctrl_hdr = 1'b0;
`endif

    vfr_ctrl_symbol_capture #(
        .SYMBOLS_PER_BEAT (SYMBOLS_PER_BEAT)
    ) u_capture (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_ctrl_start),
        .capture     (w_capture),
        .nibbles     (w_nibbles),
        .shadow_next (w_shadow_next),
        .complete    (w_complete)
    );

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b1;
        w_fwd        = 1'b0;
        w_ctrl_start = 1'b0;
        w_capture    = 1'b0;
        w_valid_next = 1'b0;
        w_error_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (din_valid && (w_hdr_video || w_pass_ctrl_hdr)) begin
                    w_ready = dout_ready;
                    w_fwd   = 1'b1;
                end
                if (din_valid && w_ready && din_sop) begin
                    if (w_hdr_video) begin
                        if (!din_eop) w_state_next = VIDEO;
                    end else if (w_hdr_ctrl) begin
                        w_ctrl_start = 1'b1;
                        if (din_eop) w_error_next = 1'b1;
                        else         w_state_next = CTRL;
                    end else if (!din_eop) begin
                        w_state_next = DISCARD;
                    end
                end
            end
            VIDEO: begin
                w_ready = dout_ready;
                w_fwd   = 1'b1;
                if (din_valid && w_ready && din_eop) w_state_next = IDLE;
            end
            CTRL: begin
`ifdef VFR_CTRL_DEC_PASSTHRU_EN
                w_ready = dout_ready;
                w_fwd   = 1'b1;
`endif
                if (din_valid && w_ready) begin
                    w_capture = 1'b1;
                    if (din_eop) begin
                        w_state_next = IDLE;
                        if (w_complete) w_valid_next = 1'b1;
                        else            w_error_next = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (din_valid && din_eop) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_width      <= '0;
            r_height     <= '0;
            r_interlaced <= '0;
            r_ctrl_valid <= 1'b0;
            r_ctrl_error <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ctrl_valid <= w_valid_next;
            r_ctrl_error <= w_error_next;
            // Slots 0..3 carry the width nibbles most-significant first.
            if (w_valid_next) begin
                r_width      <= {w_shadow_next[0], w_shadow_next[1], w_shadow_next[2], w_shadow_next[3]};
                r_height     <= {w_shadow_next[4], w_shadow_next[5], w_shadow_next[6], w_shadow_next[7]};
                r_interlaced <= w_shadow_next[8];
            end
        end
    end

    assign din_ready  = w_ready;
    assign dout_valid = w_fwd && din_valid && !rst;
    assign dout_data  = din_data;
    assign dout_sop   = din_sop;
    assign dout_eop   = din_eop;
    assign width      = r_width;
    assign height     = r_height;
    assign interlaced = r_interlaced;
    assign ctrl_valid = r_ctrl_valid;
    assign ctrl_error = r_ctrl_error;

endmodule

`default_nettype wire

// File: tb/tb_vfr_control_packet_decoder.sv
// ============================================================================
// Module   : tb_vfr_control_packet_decoder
// Brief    : Self-checking bench with a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vfr_control_packet_decoder;

    localparam int BPS = 8;
    localparam int SPB = 3;
    localparam int DW  = BPS * SPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din_data = '0;
    logic          din_sop = 1'b0;
    logic          din_eop = 1'b0;
    logic          dout_ready = 1'b1;
    logic          din_ready;
    logic          dout_valid;
    logic [DW-1:0] dout_data;
    logic          dout_sop;
    logic          dout_eop;
    logic [15:0]   width;
    logic [15:0]   height;
    logic [3:0]    interlaced;
    logic          ctrl_valid;
    logic          ctrl_error;

    always #5 clk = ~clk;

    vfr_control_packet_decoder #(
        .BITS_PER_SYMBOL  (BPS),
        .SYMBOLS_PER_BEAT (SPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_ready  (din_ready),
        .din_valid  (din_valid),
        .din_data   (din_data),
        .din_sop    (din_sop),
        .din_eop    (din_eop),
        .dout_ready (dout_ready),
        .dout_valid (dout_valid),
        .dout_data  (dout_data),
        .dout_sop   (dout_sop),
        .dout_eop   (dout_eop),
        .width      (width),
        .height     (height),
        .interlaced (interlaced),
        .ctrl_valid (ctrl_valid),
        .ctrl_error (ctrl_error)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct {
        logic        v;
        logic        e;
        logic [15:0] w;
        logic [15:0] h;
        logic [3:0]  il;
    } ev_t;

    int    tests_run = 0;
    int    tests_failed = 0;
    bit    bp_random = 1'b0;
    beat_t pkt[$];
    beat_t got_beats[$];
    beat_t exp_beats[$];
    ev_t   got_ev[$];
    ev_t   exp_ev[$];
    logic [15:0] m_w = '0;
    logic [15:0] m_h = '0;
    logic [3:0]  m_il = '0;

    // Output monitor: records completed transfers and strobe events.
    initial begin
        beat_t b;
        ev_t   e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dout_valid && dout_ready) begin
                    b.data = dout_data; b.sop = dout_sop; b.eop = dout_eop;
                    got_beats.push_back(b);
                end
                if (ctrl_valid || ctrl_error) begin
                    e.v = ctrl_valid; e.e = ctrl_error;
                    e.w = width; e.h = height; e.il = interlaced;
                    got_ev.push_back(e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_random) dout_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void add_beat(input logic [DW-1:0] d, input logic s, input logic e);
        beat_t b;
        b.data = d; b.sop = s; b.eop = e;
        pkt.push_back(b);
    endfunction

    // Packet-level reference: decide forwarding and decode from the whole packet.
    task automatic model_packet();
        logic [3:0]    hdr;
        logic [3:0]    nib[$];
        logic [DW-1:0] d;
        ev_t           e;
        exp_beats.delete();
        exp_ev.delete();
        if (pkt.size() == 0 || !pkt[0].sop) return;
        d   = pkt[0].data;
        hdr = d[3:0];
        if (hdr == 4'h0) begin
            foreach (pkt[i]) exp_beats.push_back(pkt[i]);
        end else if (hdr == 4'hF) begin
`ifdef VFR_CTRL_DEC_PASSTHRU_EN
            foreach (pkt[i]) exp_beats.push_back(pkt[i]);
`endif
            for (int b = 1; b < pkt.size(); b++) begin
                d = pkt[b].data;
                for (int s = 0; s < SPB; s++) nib.push_back(d[s*BPS +: 4]);
            end
            if (nib.size() >= 9) begin
                m_w  = {nib[0], nib[1], nib[2], nib[3]};
                m_h  = {nib[4], nib[5], nib[6], nib[7]};
                m_il = nib[8];
                e.v = 1'b1; e.e = 1'b0;
            end else begin
                e.v = 1'b0; e.e = 1'b1;
            end
            e.w = m_w; e.h = m_h; e.il = m_il;
            exp_ev.push_back(e);
        end
    endtask

    task automatic drive_packet(input int stall_idx, input int stall_cycles, input bit gaps);
        int waited;
        for (int i = 0; i < pkt.size(); i++) begin
            if (gaps) begin
                din_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            din_valid = 1'b1;
            din_data  = pkt[i].data;
            din_sop   = pkt[i].sop;
            din_eop   = pkt[i].eop;
            if (i == stall_idx) begin
                dout_ready = 1'b0;
                repeat (stall_cycles) begin
                    @(negedge clk);
                    tests_run++;
                    if (din_ready !== 1'b0 || dout_valid !== 1'b1 || dout_data !== din_data) begin
                        tests_failed++;
                        $display("FAIL stall: din_ready=%b dout_valid=%b dout_data=%h, expected 0/1/%h",
                                 din_ready, dout_valid, dout_data, din_data);
                    end
                    @(posedge clk); #1;
                end
                dout_ready = 1'b1;
            end
            waited = 0;
            forever begin
                @(negedge clk);
                if (din_ready) begin @(posedge clk); #1; break; end
                @(posedge clk); #1;
                waited++;
                if (waited > 200) begin
                    tests_failed++;
                    $display("FAIL accept_timeout: beat %0d not accepted after %0d cycles, expected acceptance", i, waited);
                    break;
                end
            end
        end
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic check_packet(input string name);
        tests_run++;
        if (got_beats.size() != exp_beats.size()) begin
            tests_failed++;
            $display("FAIL %s beat_count: got %0d, expected %0d", name, got_beats.size(), exp_beats.size());
        end
        for (int i = 0; i < got_beats.size() && i < exp_beats.size(); i++) begin
            tests_run++;
            if (got_beats[i].data !== exp_beats[i].data || got_beats[i].sop !== exp_beats[i].sop ||
                got_beats[i].eop !== exp_beats[i].eop) begin
                tests_failed++;
                $display("FAIL %s beat %0d: got %h/%b/%b, expected %h/%b/%b", name, i,
                         got_beats[i].data, got_beats[i].sop, got_beats[i].eop,
                         exp_beats[i].data, exp_beats[i].sop, exp_beats[i].eop);
            end
        end
        tests_run++;
        if (got_ev.size() != exp_ev.size()) begin
            tests_failed++;
            $display("FAIL %s event_count: got %0d, expected %0d", name, got_ev.size(), exp_ev.size());
        end
        for (int i = 0; i < got_ev.size() && i < exp_ev.size(); i++) begin
            tests_run++;
            if (got_ev[i].v !== exp_ev[i].v || got_ev[i].e !== exp_ev[i].e || got_ev[i].w !== exp_ev[i].w ||
                got_ev[i].h !== exp_ev[i].h || got_ev[i].il !== exp_ev[i].il) begin
                tests_failed++;
                $display("FAIL %s event %0d: got v=%b e=%b %h x %h il=%h, expected v=%b e=%b %h x %h il=%h",
                         name, i, got_ev[i].v, got_ev[i].e, got_ev[i].w, got_ev[i].h, got_ev[i].il,
                         exp_ev[i].v, exp_ev[i].e, exp_ev[i].w, exp_ev[i].h, exp_ev[i].il);
            end
        end
        tests_run++;
        if (width !== m_w || height !== m_h || interlaced !== m_il) begin
            tests_failed++;
            $display("FAIL %s fields: got %h x %h il=%h, expected %h x %h il=%h",
                     name, width, height, interlaced, m_w, m_h, m_il);
        end
        got_beats.delete();
        got_ev.delete();
    endtask

    task automatic run_packet(input string name, input int stall_idx, input int stall_cycles, input bit gaps);
        model_packet();
        drive_packet(stall_idx, stall_cycles, gaps);
        check_packet(name);
    endtask

    task automatic test_reset();
        din_valid = 1'b1; din_sop = 1'b1; din_eop = 1'b0; din_data = 24'h000000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_dout_valid: got %b, expected 0", dout_valid);
        end
        tests_run++;
        if (width !== 16'h0 || height !== 16'h0 || interlaced !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_fields: got %h x %h il=%h, expected 0", width, height, interlaced);
        end
        tests_run++;
        if (ctrl_valid !== 1'b0 || ctrl_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: got v=%b e=%b, expected 0/0", ctrl_valid, ctrl_error);
        end
        @(posedge clk); #1;
        rst = 1'b0; din_valid = 1'b0; din_sop = 1'b0;
        @(posedge clk); #1;
        got_beats.delete(); got_ev.delete();
    endtask

    task automatic test_ctrl_640x480();
        pkt.delete();
        add_beat(24'h00000F, 1'b1, 1'b0);
        add_beat(24'h080200, 1'b0, 1'b0);
        add_beat(24'h010000, 1'b0, 1'b0);
        add_beat(24'h03000E, 1'b0, 1'b1);
        run_packet("ctrl_640x480", -1, 0, 1'b0);
        tests_run++;
        if (width !== 16'h0280 || height !== 16'h01E0 || interlaced !== 4'h3) begin
            tests_failed++;
            $display("FAIL ctrl_640x480_const: got %h x %h il=%h, expected 0280 x 01e0 il=3",
                     width, height, interlaced);
        end
    endtask

    task automatic test_video_stall();
        pkt.delete();
        add_beat(24'h000000, 1'b1, 1'b0);
        add_beat(24'h123456, 1'b0, 1'b0);
        add_beat(24'hABCDEF, 1'b0, 1'b1);
        run_packet("video_stall", 1, 3, 1'b0);
    endtask

    task automatic test_short_ctrl();
        pkt.delete();
        add_beat(24'h00000F, 1'b1, 1'b0);
        add_beat(24'h080200, 1'b0, 1'b1);
        run_packet("short_ctrl", -1, 0, 1'b0);
        pkt.delete();
        add_beat(24'h12340F, 1'b1, 1'b1);
        run_packet("ctrl_sop_eop", -1, 0, 1'b0);
    endtask

    task automatic test_discard_then_video();
        pkt.delete();
        add_beat(24'h000005, 1'b1, 1'b0);
        add_beat(24'h111111, 1'b0, 1'b0);
        add_beat(24'h222222, 1'b0, 1'b0);
        add_beat(24'h333333, 1'b0, 1'b1);
        run_packet("discard_0x5", -1, 0, 1'b0);
        pkt.delete();
        add_beat(24'h5A5A50, 1'b1, 1'b0);
        add_beat(24'hC0FFEE, 1'b0, 1'b0);
        add_beat(24'h0F0F0F, 1'b0, 1'b1);
        run_packet("video_after_discard", -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_packet();
        pkt.delete();
        add_beat(24'h00000F, 1'b1, 1'b0);
        add_beat(24'h080200, 1'b0, 1'b0);
        drive_packet(-1, 0, 1'b0);
        din_valid = 1'b1; din_data = 24'h010000; din_sop = 1'b0; din_eop = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        m_w = '0; m_h = '0; m_il = '0;
        tests_run++;
        if (width !== 16'h0 || height !== 16'h0 || interlaced !== 4'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_fields: got %h x %h il=%h, expected 0", width, height, interlaced);
        end
        @(posedge clk); #1;
        got_beats.delete(); got_ev.delete();
        pkt.delete();
        add_beat(24'hFFFFFF, 1'b0, 1'b1);
        run_packet("stray_after_reset", -1, 0, 1'b0);
        pkt.delete();
        add_beat(24'h00000F, 1'b1, 1'b0);
        add_beat(24'h040100, 1'b0, 1'b0);
        add_beat(24'h000000, 1'b0, 1'b0);
        add_beat(24'h00000F, 1'b0, 1'b1);
        run_packet("ctrl_320x240", -1, 0, 1'b0);
        tests_run++;
        if (width !== 16'h0140 || height !== 16'h00F0) begin
            tests_failed++;
            $display("FAIL ctrl_320x240_const: got %h x %h, expected 0140 x 00f0", width, height);
        end
    endtask

    task automatic test_random();
        int            kind;
        int            len;
        logic [DW-1:0] d;
        logic [3:0]    hdr;
        bp_random = 1'b1;
        for (int p = 0; p < 40; p++) begin
            kind = $urandom_range(0, 2);
            len  = $urandom_range(1, 5);
            hdr  = (kind == 0) ? 4'h0 : (kind == 1) ? 4'hF : 4'($urandom_range(1, 14));
            pkt.delete();
            for (int b = 0; b < len; b++) begin
                d = DW'($urandom);
                if (b == 0) d[3:0] = hdr;
                add_beat(d, (b == 0) || (kind == 0 && $urandom_range(0, 7) == 0), b == len - 1);
            end
            run_packet($sformatf("random_%0d", p), -1, 0, 1'b1);
        end
        bp_random = 1'b0;
        @(posedge clk); #1;
        dout_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ctrl_640x480();
        test_video_stall();
        test_short_ctrl();
        test_discard_then_video();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
